// File: rtl/rv_pkg.sv
// Shared RV32I decode definitions: opcodes, ALU codes, control encodings and the
// control bundle carried from decode to execute.
package rv_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_MUL   = 4'd2,
    ALU_AND   = 4'd3,
    ALU_OR    = 4'd4,
    ALU_XOR   = 4'd5,
    ALU_SHL   = 4'd6,
    ALU_SHR   = 4'd7,
    ALU_SLT   = 4'd8,
    ALU_SLTU  = 4'd9,
    ALU_AUIPC = 4'd10,
    ALU_SRA   = 4'd11
  } alu_op_e;

  localparam logic [1:0] MEM_B = 2'b00;
  localparam logic [1:0] MEM_H = 2'b01;
  localparam logic [1:0] MEM_W = 2'b10;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

  localparam logic [1:0] JMP_NONE = 2'b00;
  localparam logic [1:0] JMP_JAL  = 2'b01;
  localparam logic [1:0] JMP_JALR = 2'b10;

  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic [2:0] funct3;
    alu_op_e    alu_op;
    logic       alu_src;
    logic       mem_read;
    logic       mem_write;
    logic [1:0] mem_size;
    logic       reg_write;
    logic [1:0] wb_sel;
    logic [1:0] jump;
    logic       branch;
  } ctrl_t;

  // alt selects SUB/SRA; callers only raise it where the encoding allows it.
  function automatic alu_op_e f3_to_alu(input logic [2:0] f3, input logic alt);
    alu_op_e op;
    case (f3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SHL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SHR;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/rv_decode_comb.sv
// Pure combinational RV32I(+MUL) decoder: instruction word to control bundle,
// sign-extended immediate, operand-use flags and illegal-encoding flag.
module rv_decode_comb
  import rv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter bit HAS_M = 1'b0
) (
  input  logic [31:0]     inst_i,
  output ctrl_t           ctrl_o,
  output logic [XLEN-1:0] imm_o,
  output logic            uses_rs1_o,
  output logic            uses_rs2_o,
  output logic            illegal_o
);

  logic [6:0]         opcode;
  logic [2:0]         funct3;
  logic [6:0]         funct7;
  logic signed [31:0] imm32;
  ctrl_t              ctrl;
  logic               illegal;

  assign opcode = inst_i[6:0];
  assign funct3 = inst_i[14:12];
  assign funct7 = inst_i[31:25];

  always_comb begin
    ctrl        = '0;
    ctrl.rs1    = inst_i[19:15];
    ctrl.rs2    = inst_i[24:20];
    ctrl.rd     = inst_i[11:7];
    ctrl.funct3 = funct3;
    ctrl.alu_op = ALU_ADD;
    uses_rs1_o  = 1'b1;
    uses_rs2_o  = 1'b0;
    imm32       = '0;
    illegal     = 1'b0;
    case (opcode)
      OPC_LOAD: begin
        ctrl.mem_read  = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.wb_sel    = WB_MEM;
        ctrl.mem_size  = funct3[1:0];
        imm32          = {{20{inst_i[31]}}, inst_i[31:20]};
        illegal        = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
      end
      OPC_STORE: begin
        ctrl.mem_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.mem_size  = funct3[1:0];
        uses_rs2_o     = 1'b1;
        imm32          = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
        illegal        = funct3 > 3'b010;
      end
      OPC_OPIMM: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.alu_op    = f3_to_alu(funct3, (funct3 == 3'b101) && inst_i[30]);
        imm32          = {{20{inst_i[31]}}, inst_i[31:20]};
        if (funct3 == 3'b001) illegal = funct7 != 7'b0000000;
        if (funct3 == 3'b101) illegal = (funct7 != 7'b0000000) && (funct7 != 7'b0100000);
      end
      OPC_OP: begin
        ctrl.reg_write = 1'b1;
        uses_rs2_o     = 1'b1;
        if (funct7 == 7'b0000000) begin
          ctrl.alu_op = f3_to_alu(funct3, 1'b0);
        end else if (funct7 == 7'b0100000) begin
          ctrl.alu_op = f3_to_alu(funct3, 1'b1);
          illegal     = (funct3 != 3'b000) && (funct3 != 3'b101);
        end else if (funct7 == 7'b0000001) begin
          ctrl.alu_op = ALU_MUL;
          illegal     = !HAS_M || (funct3 != 3'b000);
        end else begin
          illegal = 1'b1;
        end
      end
      OPC_LUI: begin
        ctrl.rs1       = 5'd0;
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        uses_rs1_o     = 1'b0;
        imm32          = {inst_i[31:12], 12'b0};
      end
      OPC_AUIPC: begin
        ctrl.alu_op    = ALU_AUIPC;
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        uses_rs1_o     = 1'b0;
        imm32          = {inst_i[31:12], 12'b0};
      end
      OPC_JAL: begin
        ctrl.jump      = JMP_JAL;
        ctrl.reg_write = 1'b1;
        ctrl.wb_sel    = WB_PC4;
        uses_rs1_o     = 1'b0;
        imm32          = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20],
                          inst_i[30:21], 1'b0};
      end
      OPC_JALR: begin
        ctrl.jump      = JMP_JALR;
        ctrl.reg_write = 1'b1;
        ctrl.wb_sel    = WB_PC4;
        ctrl.alu_src   = 1'b1;
        imm32          = {{20{inst_i[31]}}, inst_i[31:20]};
      end
      OPC_BRANCH: begin
        ctrl.branch = 1'b1;
        ctrl.alu_op = ALU_SUB;
        uses_rs2_o  = 1'b1;
        imm32       = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25],
                       inst_i[11:8], 1'b0};
        illegal     = funct3[2:1] == 2'b01;
      end
      default: illegal = 1'b1;
    endcase
    // Illegal encodings still flow downstream but must have no architectural effect.
    if (illegal) begin
      ctrl.reg_write = 1'b0;
      ctrl.mem_read  = 1'b0;
      ctrl.mem_write = 1'b0;
      ctrl.branch    = 1'b0;
      ctrl.jump      = JMP_NONE;
    end
  end

  assign ctrl_o    = ctrl;
  assign illegal_o = illegal;
  assign imm_o     = XLEN'(imm32);

endmodule

// File: rtl/rv_decode_stage.sv
// Registered decode stage between fetch and execute: valid/ready handshake,
// load-use hazard stall, flush, and a saturating stall-cycle counter.
module rv_decode_stage
  import rv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter bit HAS_M = 1'b0,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  logic [XLEN-1:0]  in_pc,
  input  logic             flush,
  input  logic             ex_load_valid,
  input  logic [4:0]       ex_rd,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_pc,
  output logic [4:0]       out_rs1,
  output logic [4:0]       out_rs2,
  output logic [4:0]       out_rd,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_funct3,
  output logic [3:0]       out_alu_op,
  output logic             out_alu_src,
  output logic             out_mem_read,
  output logic             out_mem_write,
  output logic [1:0]       out_mem_size,
  output logic             out_reg_write,
  output logic [1:0]       out_wb_sel,
  output logic [1:0]       out_jump,
  output logic             out_branch,
  output logic             out_illegal,
  output logic [CNT_W-1:0] stall_cycles
);

  ctrl_t            dec_ctrl;
  logic [XLEN-1:0]  dec_imm;
  logic             dec_uses_rs1, dec_uses_rs2, dec_illegal;

  ctrl_t            ctrl_q;
  logic [XLEN-1:0]  pc_q, imm_q;
  logic             illegal_q;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             hazard, capture;

  rv_decode_comb #(.XLEN(XLEN), .HAS_M(HAS_M)) u_dec (
    .inst_i     (in_inst),
    .ctrl_o     (dec_ctrl),
    .imm_o      (dec_imm),
    .uses_rs1_o (dec_uses_rs1),
    .uses_rs2_o (dec_uses_rs2),
    .illegal_o  (dec_illegal)
  );

  assign hazard = in_valid && ex_load_valid && (ex_rd != 5'd0) &&
                  ((dec_uses_rs1 && (dec_ctrl.rs1 == ex_rd)) ||
                   (dec_uses_rs2 && (dec_ctrl.rs2 == ex_rd)));

  assign in_ready = !reset && (!valid_q || out_ready) && !hazard && !flush;
  assign capture  = in_valid && in_ready;

  always_comb begin
    valid_d = valid_q;
    if (flush)          valid_d = 1'b0;
    else if (capture)   valid_d = 1'b1;
    else if (out_ready) valid_d = 1'b0;
  end

  // A flushed instruction is killed rather than stalled, so it is not counted.
  always_comb begin
    cnt_d = cnt_q;
    if (hazard && !flush && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
  end

  // ---- decode -> execute pipeline register ----
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q    <= '0;
      pc_q      <= '0;
      imm_q     <= '0;
      illegal_q <= 1'b0;
      valid_q   <= 1'b0;
      cnt_q     <= '0;
    end else begin
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
      if (capture) begin
        ctrl_q    <= dec_ctrl;
        pc_q      <= in_pc;
        imm_q     <= dec_imm;
        illegal_q <= dec_illegal;
      end
    end
  end

  assign out_valid     = valid_q;
  assign out_pc        = pc_q;
  assign out_rs1       = ctrl_q.rs1;
  assign out_rs2       = ctrl_q.rs2;
  assign out_rd        = ctrl_q.rd;
  assign out_imm       = imm_q;
  assign out_funct3    = ctrl_q.funct3;
  assign out_alu_op    = ctrl_q.alu_op;
  assign out_alu_src   = ctrl_q.alu_src;
  assign out_mem_read  = ctrl_q.mem_read;
  assign out_mem_write = ctrl_q.mem_write;
  assign out_mem_size  = ctrl_q.mem_size;
  assign out_reg_write = ctrl_q.reg_write;
  assign out_wb_sel    = ctrl_q.wb_sel;
  assign out_jump      = ctrl_q.jump;
  assign out_branch    = ctrl_q.branch;
  assign out_illegal   = illegal_q;
  assign stall_cycles  = cnt_q;

endmodule

// File: tb/tb_rv_decode_stage.sv
// Bench for rv_decode_stage: directed scenarios plus randomized traffic against an
// ISA-level decode model, on one HAS_M=0/CNT_W=4 and one HAS_M=1/CNT_W=16 instance.
module tb_rv_decode_stage;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rs1, rs2, rd;
    logic [2:0]  f3;
    logic [3:0]  alu;
    logic        src, mr, mw;
    logic [1:0]  msize;
    logic        rw;
    logic [1:0]  wb, jump;
    logic        br, ill;
    logic [31:0] imm;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, in_valid, flush, ex_load_valid, out_ready;
  logic [31:0] in_inst, in_pc;
  logic [4:0]  ex_rd;

  logic        in_ready, out_valid, out_alu_src, out_mem_read, out_mem_write;
  logic        out_reg_write, out_branch, out_illegal;
  logic [31:0] out_pc, out_imm;
  logic [4:0]  out_rs1, out_rs2, out_rd;
  logic [2:0]  out_funct3;
  logic [3:0]  out_alu_op;
  logic [1:0]  out_mem_size, out_wb_sel, out_jump;
  logic [3:0]  stall_cycles;

  logic        m_in_ready, m_out_valid, m_out_alu_src, m_out_mem_read, m_out_mem_write;
  logic        m_out_reg_write, m_out_branch, m_out_illegal;
  logic [31:0] m_out_pc, m_out_imm;
  logic [4:0]  m_out_rs1, m_out_rs2, m_out_rd;
  logic [2:0]  m_out_funct3;
  logic [3:0]  m_out_alu_op;
  logic [1:0]  m_out_mem_size, m_out_wb_sel, m_out_jump;
  logic [15:0] m_stall_cycles;

  int errors = 0;
  int checks = 0;

  rv_decode_stage #(.XLEN(32), .HAS_M(1'b0), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_inst(in_inst), .in_pc(in_pc), .flush(flush), .ex_load_valid(ex_load_valid),
    .ex_rd(ex_rd), .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd), .out_imm(out_imm),
    .out_funct3(out_funct3), .out_alu_op(out_alu_op), .out_alu_src(out_alu_src),
    .out_mem_read(out_mem_read), .out_mem_write(out_mem_write),
    .out_mem_size(out_mem_size), .out_reg_write(out_reg_write), .out_wb_sel(out_wb_sel),
    .out_jump(out_jump), .out_branch(out_branch), .out_illegal(out_illegal),
    .stall_cycles(stall_cycles)
  );

  rv_decode_stage #(.XLEN(32), .HAS_M(1'b1), .CNT_W(16)) dut_m (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(m_in_ready),
    .in_inst(in_inst), .in_pc(in_pc), .flush(flush), .ex_load_valid(ex_load_valid),
    .ex_rd(ex_rd), .out_valid(m_out_valid), .out_ready(out_ready), .out_pc(m_out_pc),
    .out_rs1(m_out_rs1), .out_rs2(m_out_rs2), .out_rd(m_out_rd), .out_imm(m_out_imm),
    .out_funct3(m_out_funct3), .out_alu_op(m_out_alu_op), .out_alu_src(m_out_alu_src),
    .out_mem_read(m_out_mem_read), .out_mem_write(m_out_mem_write),
    .out_mem_size(m_out_mem_size), .out_reg_write(m_out_reg_write),
    .out_wb_sel(m_out_wb_sel), .out_jump(m_out_jump), .out_branch(m_out_branch),
    .out_illegal(m_out_illegal), .stall_cycles(m_stall_cycles)
  );

  function automatic exp_t obs0();
    exp_t o;
    o.pc = out_pc; o.rs1 = out_rs1; o.rs2 = out_rs2; o.rd = out_rd; o.f3 = out_funct3;
    o.alu = out_alu_op; o.src = out_alu_src; o.mr = out_mem_read; o.mw = out_mem_write;
    o.msize = out_mem_size; o.rw = out_reg_write; o.wb = out_wb_sel; o.jump = out_jump;
    o.br = out_branch; o.ill = out_illegal; o.imm = out_imm;
    return o;
  endfunction

  function automatic exp_t obs1();
    exp_t o;
    o.pc = m_out_pc; o.rs1 = m_out_rs1; o.rs2 = m_out_rs2; o.rd = m_out_rd;
    o.f3 = m_out_funct3; o.alu = m_out_alu_op; o.src = m_out_alu_src;
    o.mr = m_out_mem_read; o.mw = m_out_mem_write; o.msize = m_out_mem_size;
    o.rw = m_out_reg_write; o.wb = m_out_wb_sel; o.jump = m_out_jump;
    o.br = m_out_branch; o.ill = m_out_illegal; o.imm = m_out_imm;
    return o;
  endfunction

  // ISA-level reference: expected bundle plus a mask of the fields the ISA defines.
  function automatic void ref_dec(input logic [31:0] w, input bit hm, output exp_t e,
                                  output exp_t m, output bit u1, output bit u2);
    logic [6:0]  opc, f7;
    logic [2:0]  f3;
    bit          legal;
    int          tbl [8] = '{0, 6, 8, 9, 5, 7, 4, 3};
    logic [31:0] iI, iS, iB, iU, iJ;
    opc = w[6:0]; f3 = w[14:12]; f7 = w[31:25];
    iI = {{20{w[31]}}, w[31:20]};
    iS = {{20{w[31]}}, w[31:25], w[11:7]};
    iB = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
    iU = {w[31:12], 12'b0};
    iJ = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
    e = '0; m = '0; legal = 1'b1;
    e.rs1 = w[19:15]; e.rs2 = w[24:20]; e.rd = w[11:7]; e.f3 = f3;
    u1 = !(opc inside {7'h37, 7'h17, 7'h6f});
    u2 = opc inside {7'h33, 7'h23, 7'h63};
    case (opc)
      7'h03: begin
        legal = f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        e.mr = 1; e.rw = 1; e.src = 1; e.wb = 2'b01; e.msize = f3[1:0]; e.imm = iI;
      end
      7'h23: begin
        legal = f3 <= 3'd2; e.mw = 1; e.src = 1; e.msize = f3[1:0]; e.imm = iS;
      end
      7'h13: begin
        e.rw = 1; e.src = 1; e.imm = iI; e.alu = 4'(tbl[f3]);
        if (f3 == 3'd1) legal = (f7 == 7'h00);
        if (f3 == 3'd5) begin
          legal = f7 inside {7'h00, 7'h20};
          if (f7 == 7'h20) e.alu = 4'd11;
        end
      end
      7'h33: begin
        e.rw = 1;
        if (f7 == 7'h00) e.alu = 4'(tbl[f3]);
        else if (f7 == 7'h20 && f3 == 3'd0) e.alu = 4'd1;
        else if (f7 == 7'h20 && f3 == 3'd5) e.alu = 4'd11;
        else if (f7 == 7'h01 && f3 == 3'd0 && hm) e.alu = 4'd2;
        else legal = 1'b0;
      end
      7'h37: begin e.rs1 = 5'd0; e.rw = 1; e.src = 1; e.imm = iU; end
      7'h17: begin e.alu = 4'd10; e.rw = 1; e.src = 1; e.imm = iU; end
      7'h6f: begin e.jump = 2'b01; e.rw = 1; e.wb = 2'b10; e.imm = iJ; end
      7'h67: begin e.jump = 2'b10; e.rw = 1; e.wb = 2'b10; e.imm = iI; end
      7'h63: begin e.br = 1; e.alu = 4'd1; e.imm = iB; legal = !(f3 inside {3'd2, 3'd3}); end
      default: legal = 1'b0;
    endcase
    m.ill = '1; m.rw = '1; m.mr = '1; m.mw = '1; m.br = '1; m.jump = '1; m.pc = '1;
    if (legal) begin
      m.f3 = '1;
      if (!(opc inside {7'h6f, 7'h67})) begin m.alu = '1; m.src = '1; end
      if (e.mr || e.mw) m.msize = '1;
      if (e.rw) begin m.wb = '1; m.rd = '1; end
      if (u1 || opc == 7'h37) m.rs1 = '1;
      if (u2) m.rs2 = '1;
      if (opc != 7'h33) m.imm = '1;
    end else begin
      e.rw = 0; e.mr = 0; e.mw = 0; e.br = 0; e.jump = 2'b00; e.ill = 1;
    end
  endfunction

  function automatic logic [31:0] gen_inst();
    logic [31:0] w;
    logic [6:0]  ops [9] = '{7'h03, 7'h23, 7'h13, 7'h33, 7'h37, 7'h17, 7'h6f, 7'h67, 7'h63};
    int k;
    w = $urandom;
    k = $urandom_range(0, 9);
    if (k < 9) w[6:0] = ops[k];
    w[19:15] = 5'($urandom_range(0, 7));
    w[24:20] = 5'($urandom_range(0, 7));
    if (w[6:0] == 7'h33 || (w[6:0] == 7'h13 && w[13:12] == 2'b01)) begin
      case ($urandom_range(0, 3))
        0: w[31:25] = 7'h00;
        1: w[31:25] = 7'h20;
        2: w[31:25] = 7'h01;
        default: ;
      endcase
    end
    return w;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1; in_valid = 1; in_inst = 32'h002081B3; in_pc = 32'h100; out_ready = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %0d want 0", out_valid); end
    checks++; if (out_pc !== 32'h0 || out_imm !== 32'h0) begin errors++; $display("FAIL rst_data: pc %0h imm %0h want 0", out_pc, out_imm); end
    checks++; if (out_reg_write !== 1'b0 || out_illegal !== 1'b0) begin errors++; $display("FAIL rst_ctrl: rw %0d ill %0d want 0", out_reg_write, out_illegal); end
    checks++; if (stall_cycles !== 4'd0 || m_out_valid !== 1'b0) begin errors++; $display("FAIL rst_cnt: cnt %0d mvalid %0d want 0", stall_cycles, m_out_valid); end
    tick();
    reset = 0; in_valid = 0;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %0d want 1", in_ready); end
    tick();
  endtask

  task automatic test_add();
    in_valid = 1; in_inst = 32'h002081B3; in_pc = 32'h1000; out_ready = 1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL add_ready: got %0d want 1", in_ready); end
    tick();
    in_valid = 0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL add_valid: got %0d want 1", out_valid); end
    checks++; if (out_alu_op !== 4'd0 || out_rd !== 5'd3 || out_rs1 !== 5'd1 || out_rs2 !== 5'd2)
      begin errors++; $display("FAIL add_fields: alu %0d rd %0d rs1 %0d rs2 %0d want 0 3 1 2", out_alu_op, out_rd, out_rs1, out_rs2); end
    checks++; if (out_reg_write !== 1'b1 || out_alu_src !== 1'b0 || out_illegal !== 1'b0 || out_pc !== 32'h1000)
      begin errors++; $display("FAIL add_ctrl: rw %0d src %0d ill %0d pc %0h want 1 0 0 1000", out_reg_write, out_alu_src, out_illegal, out_pc); end
    tick();
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL add_drain: got %0d want 0", out_valid); end
    tick();
  endtask

  task automatic test_load_use();
    in_valid = 1; in_inst = 32'h0080A283; in_pc = 32'h1004; out_ready = 1;
    tick();
    in_inst = 32'h00028333; in_pc = 32'h1008; ex_load_valid = 1; ex_rd = 5'd5;
    @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL lu_stall_ready: got %0d want 0", in_ready); end
    checks++; if (out_valid !== 1'b1 || out_mem_read !== 1'b1 || out_mem_size !== 2'b10 || out_wb_sel !== 2'b01)
      begin errors++; $display("FAIL lw_ctrl: v %0d mr %0d size %0d wb %0d want 1 1 2 1", out_valid, out_mem_read, out_mem_size, out_wb_sel); end
    checks++; if (out_imm !== 32'd8 || out_alu_src !== 1'b1 || out_rd !== 5'd5)
      begin errors++; $display("FAIL lw_imm: imm %0h src %0d rd %0d want 8 1 5", out_imm, out_alu_src, out_rd); end
    tick();
    ex_load_valid = 0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL lu_bubble: got %0d want 0", out_valid); end
    checks++; if (stall_cycles !== 4'd1 || m_stall_cycles !== 16'd1) begin errors++; $display("FAIL lu_count: got %0d/%0d want 1", stall_cycles, m_stall_cycles); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL lu_release: got %0d want 1", in_ready); end
    tick();
    in_valid = 0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h1008 || out_rd !== 5'd6 || out_rs1 !== 5'd5)
      begin errors++; $display("FAIL lu_capture: v %0d pc %0h rd %0d rs1 %0d want 1 1008 6 5", out_valid, out_pc, out_rd, out_rs1); end
    tick();
  endtask

  task automatic test_backpressure();
    in_valid = 1; in_inst = 32'h00100093; in_pc = 32'h2000; out_ready = 1;
    tick();
    in_inst = 32'h00200113; in_pc = 32'h2004; out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (out_valid !== 1'b1 || out_rd !== 5'd1 || out_imm !== 32'd1 || out_pc !== 32'h2000 || in_ready !== 1'b0)
        begin errors++; $display("FAIL bp_hold[%0d]: v %0d rd %0d imm %0h pc %0h rdy %0d want 1 1 1 2000 0", i, out_valid, out_rd, out_imm, out_pc, in_ready); end
      tick();
    end
    out_ready = 1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1 || out_rd !== 5'd1) begin errors++; $display("FAIL bp_release: rdy %0d rd %0d want 1 1", in_ready, out_rd); end
    tick();
    in_valid = 0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b1 || out_rd !== 5'd2 || out_imm !== 32'd2 || out_pc !== 32'h2004)
      begin errors++; $display("FAIL bp_next: v %0d rd %0d imm %0h pc %0h want 1 2 2 2004", out_valid, out_rd, out_imm, out_pc); end
    tick();
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_nodup: got %0d want 0", out_valid); end
    tick();
  endtask

  task automatic test_flush();
    in_valid = 1; in_inst = 32'h00100093; in_pc = 32'h3000; out_ready = 0;
    tick();
    in_inst = 32'h00200113; in_pc = 32'h3004; flush = 1; out_ready = 1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin errors++; $display("FAIL fl_pre: rdy %0d v %0d want 0 1", in_ready, out_valid); end
    tick();
    flush = 0; in_valid = 0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fl_kill: got %0d want 0", out_valid); end
    tick();
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fl_dropped: got %0d want 0", out_valid); end
    tick();
    in_valid = 1; in_inst = 32'h00100093; in_pc = 32'h3008; out_ready = 0;
    tick();
    reset = 1; flush = 1; in_inst = 32'h00200113;
    tick();
    @(negedge clk);
    checks++; if (out_valid !== 1'b0 || out_pc !== 32'h0 || out_rd !== 5'd0 || out_imm !== 32'h0 || out_reg_write !== 1'b0 || stall_cycles !== 4'd0)
      begin errors++; $display("FAIL fl_reset: v %0d pc %0h rd %0d imm %0h rw %0d cnt %0d want all 0", out_valid, out_pc, out_rd, out_imm, out_reg_write, stall_cycles); end
    reset = 0; flush = 0; in_valid = 0; out_ready = 1;
    tick();
  endtask

  task automatic test_illegal_mul();
    in_valid = 1; in_inst = 32'h023100B3; in_pc = 32'h4000; out_ready = 1;
    tick();
    in_inst = 32'hFFFFFFFF; in_pc = 32'h4004;
    @(negedge clk);
    checks++; if (out_illegal !== 1'b1 || out_reg_write !== 1'b0) begin errors++; $display("FAIL mul_nom: ill %0d rw %0d want 1 0", out_illegal, out_reg_write); end
    checks++; if (m_out_illegal !== 1'b0 || m_out_alu_op !== 4'd2 || m_out_reg_write !== 1'b1 || m_out_rd !== 5'd1)
      begin errors++; $display("FAIL mul_m: ill %0d alu %0d rw %0d rd %0d want 0 2 1 1", m_out_illegal, m_out_alu_op, m_out_reg_write, m_out_rd); end
    tick();
    in_inst = 32'h0080B283; in_pc = 32'h4008;
    @(negedge clk);
    checks++; if (out_illegal !== 1'b1 || out_mem_write !== 1'b0 || out_reg_write !== 1'b0 || m_out_illegal !== 1'b1)
      begin errors++; $display("FAIL ones_ill: ill %0d mw %0d rw %0d mill %0d want 1 0 0 1", out_illegal, out_mem_write, out_reg_write, m_out_illegal); end
    tick();
    in_valid = 0;
    @(negedge clk);
    checks++; if (out_illegal !== 1'b1 || out_mem_read !== 1'b0 || out_reg_write !== 1'b0)
      begin errors++; $display("FAIL ld011_ill: ill %0d mr %0d rw %0d want 1 0 0", out_illegal, out_mem_read, out_reg_write); end
    tick();
  endtask

  task automatic test_saturate();
    reset = 1;
    tick();
    reset = 0; in_valid = 1; in_inst = 32'h00028333; in_pc = 32'h5000;
    ex_load_valid = 1; ex_rd = 5'd5; out_ready = 1;
    repeat (21) tick();
    ex_load_valid = 0; in_valid = 0;
    @(negedge clk);
    checks++; if (stall_cycles !== 4'hF) begin errors++; $display("FAIL sat_cnt4: got %0d want 15", stall_cycles); end
    checks++; if (m_stall_cycles !== 16'd21) begin errors++; $display("FAIL sat_cnt16: got %0d want 21", m_stall_cycles); end
    tick();
  endtask

  task automatic test_random(input int n);
    exp_t h0, k0, h1, k1, e0, mk0, e1, mk1;
    bit   mv, hz, rdy, u1, u2;
    int   c0, c1;
    h0 = '0; k0 = '0; h1 = '0; k1 = '0; mv = 0; c0 = 0; c1 = 0;
    reset = 1; flush = 0;
    tick();
    reset = 0;
    for (int i = 0; i < n; i++) begin
      in_valid      = ($urandom_range(0, 3) != 0);
      in_inst       = gen_inst();
      in_pc         = $urandom;
      out_ready     = ($urandom_range(0, 3) != 0);
      ex_load_valid = ($urandom_range(0, 2) == 0);
      ex_rd         = 5'($urandom_range(0, 7));
      ref_dec(in_inst, 1'b0, e0, mk0, u1, u2);
      ref_dec(in_inst, 1'b1, e1, mk1, u1, u2);
      hz  = in_valid && ex_load_valid && ex_rd != 0 &&
            ((u1 && in_inst[19:15] == ex_rd) || (u2 && in_inst[24:20] == ex_rd));
      rdy = (!mv || out_ready) && !hz;
      @(negedge clk);
      checks++; if (in_ready !== rdy || m_in_ready !== rdy)
        begin errors++; $display("FAIL rnd_ready[%0d]: got %0d/%0d want %0d", i, in_ready, m_in_ready, rdy); end
      checks++; if (out_valid !== mv || m_out_valid !== mv)
        begin errors++; $display("FAIL rnd_valid[%0d]: got %0d/%0d want %0d", i, out_valid, m_out_valid, mv); end
      if (mv) begin
        checks++; if ((obs0() & k0) !== (h0 & k0))
          begin errors++; $display("FAIL rnd_bundle[%0d]: got %h want %h", i, obs0() & k0, h0 & k0); end
        checks++; if ((obs1() & k1) !== (h1 & k1))
          begin errors++; $display("FAIL rnd_bundle_m[%0d]: got %h want %h", i, obs1() & k1, h1 & k1); end
      end
      checks++; if (stall_cycles !== 4'(c0) || m_stall_cycles !== 16'(c1))
        begin errors++; $display("FAIL rnd_cnt[%0d]: got %0d/%0d want %0d/%0d", i, stall_cycles, m_stall_cycles, c0, c1); end
      if (hz) begin
        if (c0 < 15) c0++;
        c1++;
      end
      if (in_valid && rdy) begin
        e0.pc = in_pc; e1.pc = in_pc;
        h0 = e0; k0 = mk0; h1 = e1; k1 = mk1; mv = 1;
      end else if (out_ready) begin
        mv = 0;
      end
      tick();
    end
    in_valid = 0; ex_load_valid = 0;
  endtask

  initial begin
    reset = 1; in_valid = 0; in_inst = '0; in_pc = '0; flush = 0;
    ex_load_valid = 0; ex_rd = '0; out_ready = 1;
    test_reset();
    test_add();
    test_load_use();
    test_backpressure();
    test_flush();
    test_illegal_mul();
    test_saturate();
    test_random(600);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
